// File: rtl/turn_manager_pkg.sv
// Board geometry shared by the turn manager and the movement controller,
// plus the clamped tile-advance helper.
package turn_manager_pkg;

  localparam int START_X   = 20;
  localparam int STEP_X    = 40;
  localparam int LAST_TILE = 15;
  localparam int FLAG_X    = START_X + LAST_TILE * STEP_X;

  // A 5-bit sum keeps tile 15 + dice 6 from wrapping before the clamp.
  function automatic logic [3:0] clamp_tile(input logic [3:0] tile,
                                            input logic [2:0] dice,
                                            input logic [3:0] last);
    logic [4:0] sum;
    sum = {1'b0, tile} + {2'b00, dice};
    return (sum > {1'b0, last}) ? last : sum[3:0];
  endfunction

endpackage

// File: rtl/turn_manager_dice.sv
// Free-running dice counter: 1 after reset, then 1..6 wrapping every clock.
module dice_counter (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] value
);

  logic [2:0] value_q;
  logic [2:0] value_d;

  always_comb begin
    value_d = (value_q == 3'd6) ? 3'd1 : value_q + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= 3'd1;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/turn_manager.sv
// Two-player board-game turn sequencer: latches a dice roll, advances the
// active player's tile, issues the new target x and waits for the animation.
module turn_manager #(
  parameter int START_X   = turn_manager_pkg::START_X,
  parameter int STEP_X    = turn_manager_pkg::STEP_X,
  parameter int LAST_TILE = turn_manager_pkg::LAST_TILE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll_btn,
  input  logic       new_game,
  input  logic       turn_done,
  output logic [9:0] player1_pos_x,
  output logic [9:0] player2_pos_x,
  output logic       pos_valid,
  output logic       active_player,
  output logic [2:0] dice_value,
  output logic       busy,
  output logic       winner_valid,
  output logic       winner_id
);
  import turn_manager_pkg::*;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_ROLL      = 3'd1;
  localparam state_t S_ISSUE     = 3'd2;
  localparam state_t S_WAIT_DONE = 3'd3;
  localparam state_t S_GAME_OVER = 3'd4;

  localparam logic [3:0] LAST_T  = 4'(LAST_TILE);
  localparam logic [9:0] X_START = 10'(START_X);

  function automatic logic [9:0] tile_x(input logic [3:0] t);
    return 10'(START_X + int'(t) * STEP_X);
  endfunction

  state_t     state_q, state_d;
  logic       roll_prev_q;
  logic [2:0] dice_q, dice_d;
  logic [3:0] tile1_q, tile1_d, tile2_q, tile2_d;
  logic [9:0] p1x_q, p1x_d, p2x_q, p2x_d;
  logic       active_q, active_d;
  logic       pos_valid_q, pos_valid_d;
  logic       win_valid_q, win_valid_d;
  logic       win_id_q, win_id_d;

  logic [2:0] dice_cnt;
  logic       roll_edge;
  logic [3:0] active_tile;
  logic [3:0] next_tile;

  dice_counter u_dice (
    .clk   (clk),
    .rst   (rst),
    .value (dice_cnt)
  );

  assign roll_edge   = roll_btn & ~roll_prev_q;
  assign active_tile = active_q ? tile2_q : tile1_q;
  assign next_tile   = clamp_tile(active_tile, dice_q, LAST_T);

  always_comb begin
    state_d     = state_q;
    dice_d      = dice_q;
    tile1_d     = tile1_q;
    tile2_d     = tile2_q;
    p1x_d       = p1x_q;
    p2x_d       = p2x_q;
    active_d    = active_q;
    pos_valid_d = 1'b0;
    win_valid_d = win_valid_q;
    win_id_d    = win_id_q;

    // A restart outranks any roll edge or turn_done seen in the same cycle.
    if (new_game) begin
      state_d     = S_IDLE;
      dice_d      = 3'd0;
      tile1_d     = 4'd0;
      tile2_d     = 4'd0;
      p1x_d       = X_START;
      p2x_d       = X_START;
      active_d    = 1'b0;
      win_valid_d = 1'b0;
      win_id_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (roll_edge) begin
            dice_d  = dice_cnt;
            state_d = S_ROLL;
          end
        end
        S_ROLL: begin
          if (active_q) begin
            tile2_d = next_tile;
            p2x_d   = tile_x(next_tile);
          end else begin
            tile1_d = next_tile;
            p1x_d   = tile_x(next_tile);
          end
          pos_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
        S_ISSUE: state_d = S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (turn_done) begin
            if (active_tile == LAST_T) begin
              win_valid_d = 1'b1;
              win_id_d    = active_q;
              state_d     = S_GAME_OVER;
            end else begin
              active_d = ~active_q;
              state_d  = S_IDLE;
            end
          end
        end
        S_GAME_OVER: state_d = S_GAME_OVER;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      roll_prev_q <= 1'b0;
      dice_q      <= 3'd0;
      tile1_q     <= 4'd0;
      tile2_q     <= 4'd0;
      p1x_q       <= X_START;
      p2x_q       <= X_START;
      active_q    <= 1'b0;
      pos_valid_q <= 1'b0;
      win_valid_q <= 1'b0;
      win_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      roll_prev_q <= roll_btn;
      dice_q      <= dice_d;
      tile1_q     <= tile1_d;
      tile2_q     <= tile2_d;
      p1x_q       <= p1x_d;
      p2x_q       <= p2x_d;
      active_q    <= active_d;
      pos_valid_q <= pos_valid_d;
      win_valid_q <= win_valid_d;
      win_id_q    <= win_id_d;
    end
  end

  assign player1_pos_x = p1x_q;
  assign player2_pos_x = p2x_q;
  assign pos_valid     = pos_valid_q;
  assign active_player = active_q;
  assign dice_value    = dice_q;
  assign busy          = (state_q == S_ROLL) || (state_q == S_ISSUE) ||
                         (state_q == S_WAIT_DONE);
  assign winner_valid  = win_valid_q;
  assign winner_id     = win_id_q;

endmodule

// File: tb/tb_turn_manager.sv
// Scoreboard bench for turn_manager: rolls push expected pos_valid beats,
// a negedge monitor pops and compares them.
module tb_turn_manager;

  logic       clk = 1'b0;
  logic       rst;
  logic       roll_btn;
  logic       new_game;
  logic       turn_done;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       pos_valid;
  logic       active_player;
  logic [2:0] dice_value;
  logic       busy;
  logic       winner_valid;
  logic       winner_id;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    int         cyc;
    logic [9:0] p1;
    logic [9:0] p2;
    logic       act;
    logic [2:0] dice;
  } exp_t;
  exp_t sb_q[$];

  int tb_dice;
  int cycle_cnt;
  int tile_m[2];
  bit act_m;

  turn_manager dut (
    .clk           (clk),
    .rst           (rst),
    .roll_btn      (roll_btn),
    .new_game      (new_game),
    .turn_done     (turn_done),
    .player1_pos_x (player1_pos_x),
    .player2_pos_x (player2_pos_x),
    .pos_valid     (pos_valid),
    .active_player (active_player),
    .dice_value    (dice_value),
    .busy          (busy),
    .winner_valid  (winner_valid),
    .winner_id     (winner_id)
  );

  always #5 clk = ~clk;

  // Reference dice sequence and cycle counter
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_dice   <= 1;
      cycle_cnt <= 0;
    end else begin
      tb_dice   <= (tb_dice == 6) ? 1 : tb_dice + 1;
      cycle_cnt <= cycle_cnt + 1;
    end
  end

  function automatic int x_of(input int t);
    return 20 + 40 * t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // Monitor: every pos_valid beat must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && pos_valid) begin
      if (sb_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_pos_valid: got pos_valid=1 at cycle %0d, expected none",
                 cycle_cnt);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pv_cycle", cycle_cnt, e.cyc);
        check("pv_p1x", int'(player1_pos_x), int'(e.p1));
        check("pv_p2x", int'(player2_pos_x), int'(e.p2));
        check("pv_active", int'(active_player), int'(e.act));
        check("pv_dice", int'(dice_value), int'(e.dice));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_roll(input int d, input int hold);
    exp_t e;
    int n;
    n = 0;
    while (tb_dice != d && n < 12) begin
      tick();
      n++;
    end
    check("dice_sync_timeout", tb_dice, d);
    roll_btn = 1'b1;
    tile_m[act_m] = (tile_m[act_m] + d > 15) ? 15 : tile_m[act_m] + d;
    e.cyc  = cycle_cnt + 2;
    e.p1   = 10'(x_of(tile_m[0]));
    e.p2   = 10'(x_of(tile_m[1]));
    e.act  = act_m;
    e.dice = 3'(d);
    sb_q.push_back(e);
    repeat (hold) tick();
    roll_btn = 1'b0;
    repeat (2) tick();
    check("roll_dice_value", int'(dice_value), d);
    check("roll_busy", int'(busy), 1);
  endtask

  task automatic do_done(input bit in_wait);
    turn_done = 1'b1;
    tick();
    turn_done = 1'b0;
    if (in_wait && tile_m[act_m] != 15) act_m = ~act_m;
    check("done_active", int'(active_player), int'(act_m));
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    tile_m[0] = 0;
    tile_m[1] = 0;
    act_m = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_p1x"}, int'(player1_pos_x), 20);
    check({tag, "_p2x"}, int'(player2_pos_x), 20);
    check({tag, "_pos_valid"}, int'(pos_valid), 0);
    check({tag, "_active"}, int'(active_player), 0);
    check({tag, "_dice"}, int'(dice_value), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_win_valid"}, int'(winner_valid), 0);
    check({tag, "_win_id"}, int'(winner_id), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    roll_btn = 1'b0;
    new_game = 1'b0;
    turn_done = 1'b0;
    tile_m[0] = 0;
    tile_m[1] = 0;
    act_m = 1'b0;
    repeat (2) tick();
    check_cleared("reset");
    rst = 1'b0;

    // First roll: counter 3 -> tile 3, x=140
    do_roll(3, 1);
    check("p1x_after_3", int'(player1_pos_x), 140);
    do_done(1'b1);

    // Held button yields one roll; turn_done in IDLE is ignored
    do_roll(5, 50);
    check("p2x_after_hold", int'(player2_pos_x), 220);
    do_done(1'b1);
    do_done(1'b0);
    check("idle_busy", int'(busy), 0);

    // Walk player1 to tile 13, then to the flag
    do_roll(6, 1); do_done(1'b1);
    do_roll(2, 1); do_done(1'b1);
    do_roll(4, 1);
    check("p1x_tile13", int'(player1_pos_x), 540);
    do_done(1'b1);
    do_roll(1, 1); do_done(1'b1);
    do_roll(6, 1);
    check("p1x_flag", int'(player1_pos_x), 620);
    do_done(1'b1);
    check("winner_valid", int'(winner_valid), 1);
    check("winner_id", int'(winner_id), 0);
    check("over_busy", int'(busy), 0);

    // Rolls in GAME_OVER must produce nothing; outputs stay put
    roll_btn = 1'b1; tick(); roll_btn = 1'b0;
    repeat (2) tick();
    roll_btn = 1'b1; tick(); roll_btn = 1'b0;
    repeat (5) tick();
    check("over_p1x_stable", int'(player1_pos_x), 620);
    check("over_p2x_stable", int'(player2_pos_x), 340);
    check("over_winner_stable", int'(winner_valid), 1);

    pulse_new_game();
    check_cleared("newgame");

    // Player2 at x=300, then new_game while waiting and a stale turn_done
    do_roll(1, 1); do_done(1'b1);
    do_roll(6, 1); do_done(1'b1);
    do_roll(2, 1); do_done(1'b1);
    do_roll(1, 1);
    check("p2x_300", int'(player2_pos_x), 300);
    pulse_new_game();
    check("ng_wait_p1x", int'(player1_pos_x), 20);
    check("ng_wait_p2x", int'(player2_pos_x), 20);
    check("ng_wait_active", int'(active_player), 0);
    check("ng_wait_busy", int'(busy), 0);
    do_done(1'b0);
    check("stale_done_busy", int'(busy), 0);

    // new_game beats a simultaneous roll edge
    do_roll(2, 1);
    check("p1x_tile2", int'(player1_pos_x), 100);
    do_done(1'b1);
    new_game = 1'b1;
    roll_btn = 1'b1;
    tick();
    new_game = 1'b0;
    roll_btn = 1'b0;
    tile_m[0] = 0; tile_m[1] = 0; act_m = 1'b0;
    repeat (4) tick();
    check("ng_roll_dice", int'(dice_value), 0);
    check("ng_roll_busy", int'(busy), 0);
    check("ng_roll_active", int'(active_player), 0);

    // Asynchronous reset while in ISSUE
    roll_btn = 1'b1; tick(); roll_btn = 1'b0; tick();
    check("issue_pos_valid", int'(pos_valid), 1);
    rst = 1'b1;
    #1;
    check_cleared("async_rst");
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check_cleared("post_rst");

    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/turn_manager.md
TURN_MANAGER -- requirements
Module: turn_manager

Interface
REQ-001 SHALL have parameter START_X, default 20: pixel x of tile 0.
REQ-002 SHALL have parameter STEP_X, default 40: pixels per tile.
REQ-003 SHALL have parameter LAST_TILE, default 15: flag tile; x = START_X + LAST_TILE*STEP_X = 620.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port roll_btn, input, 1 bit: dice-roll request, level; only rising edges count.
REQ-007 SHALL have port new_game, input, 1 bit: synchronous restart, sampled each clk.
REQ-008 SHALL have port turn_done, input, 1 bit: 1-cycle pulse from the movement controller when the animation finishes.
REQ-009 SHALL have ports player1_pos_x and player2_pos_x, output, 10 bits each: target x per player.
REQ-010 SHALL have port pos_valid, output, 1 bit: 1-cycle pulse meaning the pos_x outputs and active_player are valid.
REQ-011 SHALL have port active_player, output, 1 bit: 0 = Player1, 1 = Player2.
REQ-012 SHALL have port dice_value, output, 3 bits: last roll, 1..6; 0 = no roll yet.
REQ-013 SHALL have ports busy, winner_valid and winner_id, output, 1 bit each.

Function
REQ-014 SHALL run a dice counter that is 1 after reset and advances 1->2->...->6->1 every clk, in every state.
REQ-015 SHALL detect roll_btn rising edges with a registered previous value; a held button yields one roll.
REQ-016 SHALL implement states IDLE, ROLL, ISSUE, WAIT_DONE, GAME_OVER.
REQ-017 IDLE: on a roll edge, SHALL latch dice_value from the dice counter's current value and go to ROLL.
REQ-018 ROLL: SHALL compute tile = min(tile[active] + dice_value, LAST_TILE), update that player's pos_x register, and go to ISSUE.
REQ-019 Tile arithmetic: 4-bit tile plus 3-bit dice SHALL use a 5-bit sum before clamping; pos_x SHALL be START_X + tile*STEP_X, registered, 10 bits.
REQ-020 ISSUE: pos_valid SHALL be 1 for exactly this one cycle (registered), then the FSM SHALL go to WAIT_DONE; pos_valid SHALL be 0 in all other states.
REQ-021 pos_valid SHALL rise 2 clk after the cycle in which the roll edge is detected, and SHALL be low for at least 1 cycle between pulses.
REQ-022 WAIT_DONE: on turn_done, if tile[active] == LAST_TILE, SHALL go to GAME_OVER with winner_valid=1 and winner_id=active_player.
REQ-023 WAIT_DONE: on turn_done with no win, SHALL toggle active_player and go to IDLE.
REQ-024 turn_done outside WAIT_DONE SHALL be ignored.
REQ-025 Roll edges outside IDLE SHALL be ignored, not queued.
REQ-026 busy SHALL be 1 in ROLL, ISSUE and WAIT_DONE, and 0 otherwise.
REQ-027 GAME_OVER SHALL hold until new_game; winner_valid, winner_id and the pos_x outputs SHALL stay stable.
REQ-028 new_game SHALL take effect from any state: tiles 0, pos_x = START_X, active_player 0, dice_value 0, winner cleared, state IDLE.
REQ-029 new_game SHALL take priority over a roll edge or turn_done in the same cycle.

Reset
REQ-030 On rst, immediately: state IDLE, player1_pos_x = player2_pos_x = 20, pos_valid 0, active_player 0, dice_value 0, busy 0, winner_valid 0, winner_id 0, dice counter 1, roll edge register 0.

Structure
REQ-031 A shared package SHALL hold START_X, STEP_X, LAST_TILE and FLAG_X, so these match the movement controller.
REQ-032 The state typedef SHALL be local to turn_manager.
REQ-033 The dice counter SHALL be one sub-module, dice_counter (clk, rst, 3-bit value).

Verification
REQ-034 Reset, then roll_btn edge detected while the counter is 3 -> dice_value=3, player1_pos_x=140, pos_valid high 1 cycle exactly 2 clk later; turn_done -> active_player=1.
REQ-035 Hold roll_btn high 50 cycles -> one pos_valid; pulse turn_done in IDLE -> active_player unchanged.
REQ-036 Player1 at tile 13 (x=540), rolls 6 -> player1_pos_x=620; turn_done -> winner_valid=1, winner_id=0; later roll edges produce no pos_valid.
REQ-037 new_game during WAIT_DONE with player2 at x=300 -> both pos_x=20, active_player=0, busy=0; a stale turn_done next cycle is ignored.
REQ-038 Assert rst during ISSUE -> pos_valid=0 in the same cycle, before any clk edge; all outputs take the REQ-030 values.
REQ-039 new_game and a roll edge in the same cycle -> no pos_valid; dice_value=0.
